// File: rtl/arb_mux_n_pkg.sv
// Shared constants and helpers for the N-channel arbitrating data selector.
package arb_mux_n_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   // Next round-robin start position: one past the winner, wrapping at n.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/arb_mux_n_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module arb_mux_n_rr_arbiter
   import arb_mux_n_pkg::*;
#(
   parameter  int NCH  = 4,
   localparam int SELW = $clog2(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic [NCH-1:0]  gnt,
   output logic [SELW-1:0] gnt_idx,
   output logic            any_gnt
);

   logic [2*NCH-1:0] req_dbl;
   int               base;
   int               pos;

   // Scanning a doubled request vector from ptr upward avoids a modulo in the loop.
   always_comb begin
      req_dbl = {req, req};
      base    = (int'(ptr) < NCH) ? int'(ptr) : 0;
      pos     = 0;
      any_gnt = 1'b0;
      gnt     = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (req_dbl[base + k]) begin
            any_gnt = 1'b1;
            pos     = base + k;
         end
      end
      if (pos >= NCH) begin
         pos = pos - NCH;
      end
      gnt_idx = SELW'(pos);
      if (any_gnt) begin
         gnt[pos] = 1'b1;
      end
   end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel WIDTH-bit selector (direct or round-robin) with a registered valid/ready output stage.
module arb_mux_n
   import arb_mux_n_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int NCH   = 4,
   localparam int SELW  = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic [NCH*WIDTH-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch
);

   logic             out_valid_reg;
   logic [WIDTH-1:0] out_data_reg;
   logic [SELW-1:0]  out_ch_reg;
   logic [SELW-1:0]  rr_ptr_reg;
   logic [SELW-1:0]  rr_ptr_next;

   logic [WIDTH-1:0] ch_data [NCH];
   logic [NCH-1:0]   gnt;
   logic [NCH-1:0]   dir_hit;
   logic [NCH-1:0]   xfer_vec;
   logic [SELW-1:0]  gnt_idx;
   logic             any_gnt;
   logic             sel_ok;
   logic             load_en;
   logic             rr_xfer;
   logic             dir_xfer;
   logic             any_xfer;
   logic [SELW-1:0]  xfer_idx;
   logic [WIDTH-1:0] data_next;

   arb_mux_n_rr_arbiter #(.NCH(NCH)) u_rr_arbiter (
      .req     (in_valid),
      .ptr     (rr_ptr_reg),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_gnt (any_gnt)
   );

   // Gating with rst_n keeps every ready low while reset is held.
   assign load_en = rst_n && (!out_valid_reg || out_ready);
   assign sel_ok  = int'(sel) < NCH;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
         assign dir_hit[gi]  = sel_ok && (sel == SELW'(gi));
         assign in_ready[gi] = load_en && ((mode == MODE_RR) ? gnt[gi] : dir_hit[gi]);
      end
   endgenerate

   assign xfer_vec    = in_valid & in_ready;
   assign rr_xfer     = load_en && any_gnt;
   assign dir_xfer    = load_en && |(dir_hit & in_valid);
   assign any_xfer    = (mode == MODE_RR) ? rr_xfer : dir_xfer;
   assign xfer_idx    = (mode == MODE_RR) ? gnt_idx : sel;
   assign rr_ptr_next = SELW'(wrap_inc(int'(gnt_idx), NCH));

   // At most one transfer bit is set, so an OR-reduction acts as the data mux.
   always_comb begin
      data_next = '0;
      for (int i = 0; i < NCH; i++) begin
         if (xfer_vec[i]) begin
            data_next = data_next | ch_data[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_ch_reg    <= '0;
         rr_ptr_reg    <= '0;
      end else if (load_en) begin
         out_valid_reg <= any_xfer;
         if (any_xfer) begin
            out_data_reg <= data_next;
            out_ch_reg   <= xfer_idx;
            if (mode == MODE_RR) begin
               rr_ptr_reg <= rr_ptr_next;
            end
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed bench for arb_mux_n: a 4-channel 32-bit instance plus a 3-channel 8-bit one for the invalid-sel case.
module tb_arb_mux_n;

   logic         clk = 1'b0;
   logic         rst_n;

   logic         mode;
   logic [1:0]   sel;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_data;
   logic [1:0]   out_ch;

   logic         mode3;
   logic [1:0]   sel3;
   logic [2:0]   in_valid3;
   logic [2:0]   in_ready3;
   logic [23:0]  in_data3;
   logic         out_valid3;
   logic         out_ready3;
   logic [7:0]   out_data3;
   logic [1:0]   out_ch3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   arb_mux_n #(.WIDTH(32), .NCH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch)
   );

   arb_mux_n #(.WIDTH(8), .NCH(3)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode3),
      .sel       (sel3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .in_data   (in_data3),
      .out_valid (out_valid3),
      .out_ready (out_ready3),
      .out_data  (out_data3),
      .out_ch    (out_ch3)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic edge_out();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int i, input logic [31:0] d);
      in_data[i*32 +: 32] = d;
   endtask

   // Continuous checks: one-hot ready, stable output under stall, one line per consumed beat.
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data  = '0;
   logic [1:0]  prev_ch    = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         check("onehot_ready4", 64'($onehot0(in_ready)), 64'd1);
         check("onehot_ready3", 64'($onehot0(in_ready3)), 64'd1);
         if (prev_stall) begin
            check("stall_stable", {out_ch, out_data}, {prev_ch, prev_data});
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_ch    = out_ch;
         if (out_valid && out_ready)
            $display("beat  ch=%0d data=%08h t=%0t", out_ch, out_data, $time);
         if (out_valid3 && out_ready3)
            $display("beat3 ch=%0d data=%02h t=%0t", out_ch3, out_data3, $time);
      end
   end

   logic [3:0] t3_valid [4] = '{4'b0001, 4'b1001, 4'b1001, 4'b1001};
   int         t3_ch    [4] = '{0, 3, 0, 3};
   logic [3:0] exp_rdy;

   initial begin
      rst_n      = 1'b0;
      mode       = 1'b0;
      sel        = 2'd0;
      in_valid   = '0;
      in_data    = '0;
      out_ready  = 1'b0;
      mode3      = 1'b0;
      sel3       = 2'd0;
      in_valid3  = '0;
      in_data3   = '0;
      out_ready3 = 1'b0;

      // Reset state: ready must stay low even though direct mode selects ch0.
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_ch", out_ch, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_in_ready3", in_ready3, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // 1. Direct mode, sel=2.
      mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
      set_ch(2, 32'hDEAD_BEEF);
      #1; check("t1_ready", in_ready, 4'b0100);
      edge_out();
      check("t1_valid", out_valid, 1);
      check("t1_data", out_data, 32'hDEAD_BEEF);
      check("t1_ch", out_ch, 2);
      #1;

      // 2. Round-robin fairness with all channels valid; pointer untouched by the direct beat.
      mode = 1'b1; in_valid = 4'b1111;
      for (int i = 0; i < 4; i++) set_ch(i, 32'h1000 + i);
      for (int k = 0; k < 8; k++) begin
         exp_rdy = 4'b0001 << (k % 4);
         #1; check("t2_ready", in_ready, exp_rdy);
         edge_out();
         check("t2_valid", out_valid, 1);
         check("t2_ch", out_ch, k % 4);
         check("t2_data", out_data, 32'h1000 + (k % 4));
         #1;
      end

      // 3. Skip idle channels: move ptr to 1 with a ch0 beat, then alternate 3,0,3.
      for (int k = 0; k < 4; k++) begin
         in_valid = t3_valid[k];
         exp_rdy  = 4'b0001 << t3_ch[k];
         #1; check("t3_ready", in_ready, exp_rdy);
         edge_out();
         check("t3_ch", out_ch, t3_ch[k]);
         check("t3_data", out_data, 32'h1000 + t3_ch[k]);
         #1;
      end

      // 4. Backpressure on ch1 in direct mode.
      mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
      set_ch(1, 32'hAAAA_0001);
      #1; check("t4_load_ready", in_ready, 4'b0010);
      edge_out();
      check("t4_load_data", out_data, 32'hAAAA_0001);
      #1;
      out_ready = 1'b0;
      set_ch(1, 32'hBBBB_0002);
      for (int k = 0; k < 3; k++) begin
         #1; check("t4_stall_ready", in_ready, 0);
         edge_out();
         check("t4_stall_valid", out_valid, 1);
         check("t4_stall_data", out_data, 32'hAAAA_0001);
         #1;
      end
      out_ready = 1'b1;
      #1; check("t4_release_ready", in_ready, 4'b0010);
      edge_out();
      check("t4_nobubble_valid", out_valid, 1);
      check("t4_nobubble_data", out_data, 32'hBBBB_0002);
      check("t4_nobubble_ch", out_ch, 1);
      #1;
      in_valid = 4'b0000;
      #1; check("t4_ready_not_valid", in_ready, 4'b0010);
      edge_out();
      check("t4_drain_valid", out_valid, 0);
      check("t4_hold_data", out_data, 32'hBBBB_0002);
      #1;

      // 5. Out-of-range sel on the 3-channel build.
      mode3 = 1'b0; sel3 = 2'd1; in_valid3 = 3'b111; out_ready3 = 1'b1;
      in_data3 = {8'h33, 8'h5A, 8'h11};
      #1; check("t5_ready_sel1", in_ready3, 3'b010);
      edge_out();
      check("t5_load_valid", out_valid3, 1);
      check("t5_load_data", out_data3, 8'h5A);
      #1;
      sel3 = 2'd3;
      #1; check("t5_ready_sel3", in_ready3, 3'b000);
      edge_out();
      check("t5_drain_valid", out_valid3, 0);
      check("t5_hold_data", out_data3, 8'h5A);
      check("t5_hold_ch", out_ch3, 1);
      #1;
      in_valid3 = '0; out_ready3 = 1'b0; sel3 = 2'd0;

      // 6. Reset in the middle of a stall; ptr sits at 3 after the ch2 beat.
      mode = 1'b1; in_valid = 4'b0100; out_ready = 1'b1;
      #1; check("t6_ready", in_ready, 4'b0100);
      edge_out();
      check("t6_load_ch", out_ch, 2);
      #1;
      out_ready = 1'b0; in_valid = 4'b1111;
      edge_out();
      check("t6_stall_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_data", out_data, 0);
      check("t6_rst_ch", out_ch, 0);
      check("t6_rst_ready", in_ready, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1; out_ready = 1'b1;
      #1; check("t6_restart_ready", in_ready, 4'b0001);
      edge_out();
      check("t6_restart_ch", out_ch, 0);
      check("t6_restart_data", out_data, 32'h1000);
      #1;
      in_valid = '0;
      edge_out();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
